c_wf_req_master: RTL and testbench

//  Requester side of the wavefront allocator interface: accepts a prioritized

---
 rtl/c_wf_req_master.sv | 187 ++++++++++++++++++
 tb/tb_c_wf_req_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_wf_req_master.sv
//------------------------------------------------------------------------------
// Module   : c_wf_req_master
// Brief    : Requester front-end for a wavefront allocator. Drains a loaded
//            prioritized request matrix by retiring granted bits each cycle
//            and reports drain latency, watchdog aborts and illegal grants.
// Options  : WF_REQ_CHECK_EN enables the sticky grant-legality checker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module c_wf_req_master #(
    parameter int NUM_PORTS      = 8,
    parameter int NUM_PRIORITIES = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int MAX_CYCLES     = 0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          load_valid,
    output logic                                          load_ready,
    input  logic [NUM_PRIORITIES*NUM_PORTS*NUM_PORTS-1:0] load_req_pr,
    output logic [NUM_PRIORITIES*NUM_PORTS*NUM_PORTS-1:0] req_pr,
    output logic                                          update,
    input  logic [NUM_PRIORITIES*NUM_PORTS*NUM_PORTS-1:0] gnt_pr,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          timeout,
    output logic [CNT_WIDTH-1:0]                          elapsed,
    output logic                                          error
);

    localparam int c_N = NUM_PORTS;
    localparam int c_P = NUM_PRIORITIES;
    localparam int c_W = c_P * c_N * c_N;

    localparam logic c_ST_IDLE   = 1'b0;
    localparam logic c_ST_ACTIVE = 1'b1;

    localparam logic [CNT_WIDTH:0] c_WD_LIMIT = (CNT_WIDTH + 1)'(MAX_CYCLES);
    localparam bit                 c_WD_EN    = (MAX_CYCLES != 0);

    logic                 r_state;
    logic                 w_state_nxt;
    logic [c_W-1:0]       r_pending;
    logic [c_W-1:0]       w_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_sat;
    logic [CNT_WIDTH:0]   w_cnt_p1;
    logic                 r_done;
    logic                 r_timeout;
    logic [CNT_WIDTH-1:0] r_elapsed;
    logic                 w_handshake;
    logic                 w_load_zero;
    logic                 w_drain;
    logic                 w_wd_hit;

    assign w_handshake = load_valid & (r_state == c_ST_IDLE);
    assign w_load_zero = (load_req_pr == '0);
    assign w_nxt       = r_pending & ~gnt_pr;
    assign w_drain     = (w_nxt == '0);
    // Extra bit keeps the watchdog compare exact even when the counter is saturated.
    assign w_cnt_p1    = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_cnt_sat   = (&r_cnt) ? r_cnt : w_cnt_p1[CNT_WIDTH-1:0];
    assign w_wd_hit    = c_WD_EN && (w_cnt_p1 == c_WD_LIMIT) && !w_drain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_handshake && !w_load_zero) begin
                    w_state_nxt = c_ST_ACTIVE;
                end
            end
            c_ST_ACTIVE: begin
                if (w_drain || w_wd_hit) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready = (r_state == c_ST_IDLE);
        busy       = (r_state == c_ST_ACTIVE);
        req_pr     = r_pending;
        update     = |r_pending;
        done       = r_done;
        timeout    = r_timeout;
        elapsed    = r_elapsed;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_elapsed <= '0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (w_handshake) begin
                    if (w_load_zero) begin
                        r_done    <= 1'b1;
                        r_elapsed <= '0;
                    end else begin
                        r_pending <= load_req_pr;
                        r_cnt     <= '0;
                    end
                end
            end else begin
                r_cnt     <= w_cnt_sat;
                r_pending <= w_nxt;
                if (w_drain) begin
                    r_done    <= 1'b1;
                    r_elapsed <= w_cnt_sat;
                end else if (w_wd_hit) begin
                    r_pending <= '0;
                    r_done    <= 1'b1;
                    r_timeout <= 1'b1;
                    r_elapsed <= c_WD_LIMIT[CNT_WIDTH-1:0];
                end
            end
        end
    end

`ifdef WF_REQ_CHECK_EN
    logic w_illegal;
    logic r_error;

    always_comb begin : p_check
        logic [c_N-1:0]     row_seen;
        logic [c_N-1:0]     row_multi;
        logic [c_N-1:0]     col_seen;
        logic [c_N-1:0]     col_multi;
        logic [c_N*c_N-1:0] cell_seen;
        logic [c_N*c_N-1:0] cell_multi;
        logic               b;
        row_seen   = '0;
        row_multi  = '0;
        col_seen   = '0;
        col_multi  = '0;
        cell_seen  = '0;
        cell_multi = '0;
        b          = 1'b0;
        for (int p = 0; p < c_P; p++) begin
            for (int i = 0; i < c_N; i++) begin
                for (int o = 0; o < c_N; o++) begin
                    b = gnt_pr[(p*c_N+i)*c_N+o];
                    row_multi[i]        = row_multi[i] | (row_seen[i] & b);
                    row_seen[i]         = row_seen[i] | b;
                    col_multi[o]        = col_multi[o] | (col_seen[o] & b);
                    col_seen[o]         = col_seen[o] | b;
                    cell_multi[i*c_N+o] = cell_multi[i*c_N+o] | (cell_seen[i*c_N+o] & b);
                    cell_seen[i*c_N+o]  = cell_seen[i*c_N+o] | b;
                end
            end
        end
        w_illegal = (|(gnt_pr & ~r_pending)) | (|row_multi) | (|col_multi) | (|cell_multi);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if ((r_state == c_ST_ACTIVE) && w_illegal) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_c_wf_req_master.sv
//------------------------------------------------------------------------------
// Module   : tb_c_wf_req_master
// Brief    : Scoreboard bench for c_wf_req_master with an allocator grant model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_c_wf_req_master;

    localparam int N    = 8;
    localparam int P    = 2;
    localparam int T    = P * N * N;
    localparam int CW   = 16;
    localparam int MAXC = 10;

    localparam int M_RAND    = 0;
    localparam int M_GREEDY  = 1;
    localparam int M_ONE     = 2;
    localparam int M_NONE    = 3;
    localparam int M_ILLEGAL = 4;

    typedef struct {
        logic [CW-1:0] el;
        logic          to;
        int            upd;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [T-1:0]  load_req_pr;
    logic [T-1:0]  req_pr;
    logic          update;
    logic [T-1:0]  gnt_pr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] elapsed;
    logic          error;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   upd_cnt = 0;
    logic exp_error = 1'b0;

    c_wf_req_master #(
        .NUM_PORTS     (N),
        .NUM_PRIORITIES(P),
        .CNT_WIDTH     (CW),
        .MAX_CYCLES    (MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_req_pr(load_req_pr),
        .req_pr     (req_pr),
        .update     (update),
        .gnt_pr     (gnt_pr),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .elapsed    (elapsed),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [T-1:0] act, input logic [T-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Allocator stand-in: legal grants unless the illegal mode is requested.
    function automatic logic [T-1:0] pick(input logic [T-1:0] pend, input int mode);
        logic [T-1:0] g;
        logic [N-1:0] row_used;
        logic [N-1:0] col_used;
        int start;
        int idx;
        int i;
        int o;
        g        = '0;
        row_used = '0;
        col_used = '0;
        if (mode == M_NONE) return '0;
        if (mode == M_ILLEGAL) return pend;
        if (mode == M_ONE) begin
            for (int k = 0; k < T; k++) begin
                if (pend[k]) begin
                    g[k] = 1'b1;
                    return g;
                end
            end
            return '0;
        end
        start = $urandom_range(0, T - 1);
        for (int k = 0; k < T; k++) begin
            idx = (start + k) % T;
            o   = idx % N;
            i   = (idx / N) % N;
            if (pend[idx] && !row_used[i] && !col_used[o] &&
                (mode == M_GREEDY || ($urandom % 2) == 0)) begin
                g[idx]      = 1'b1;
                row_used[i] = 1'b1;
                col_used[o] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic run_matrix(input logic [T-1:0] m, input int mode);
        logic [T-1:0] gq[$];
        logic [T-1:0] pend;
        logic [T-1:0] g;
        int   cyc;
        int   w;
        exp_t e;
        logic to;
        pend = m;
        cyc  = 0;
        to   = 1'b0;
        while (pend != '0 && cyc < 1000) begin
            g = pick(pend, mode);
            gq.push_back(g);
            pend = pend & ~g;
            cyc++;
            if (pend != '0 && MAXC != 0 && cyc == MAXC) begin
                to = 1'b1;
                break;
            end
        end
        e.el  = CW'(cyc);
        e.to  = to;
        e.upd = cyc;
        sb_q.push_back(e);
`ifdef WF_REQ_CHECK_EN
        if (mode == M_ILLEGAL) exp_error = 1'b1;
`endif
        w = 0;
        while (!load_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("ready_before_load", T'(load_ready), T'(1));
        load_valid  = 1'b1;
        load_req_pr = m;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        pend = m;
        foreach (gq[k]) begin
            check("req_pr_drain", req_pr, pend);
            check("update_drain", T'(update), T'(1));
            check("busy_drain", T'(busy), T'(1));
            gnt_pr = gq[k];
            @(posedge clk);
            #1;
            pend = pend & ~gq[k];
        end
        gnt_pr = '0;
        check("req_pr_after", req_pr, '0);
        check("busy_after", T'(busy), T'(0));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            upd_cnt = 0;
        end else begin
            if (update) upd_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no pulse");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("elapsed", T'(elapsed), T'(mon_e.el));
                    check("timeout", T'(timeout), T'(mon_e.to));
                    check("update_cycles", T'(upd_cnt), T'(mon_e.upd));
                    check("ready_at_done", T'(load_ready), T'(1));
                end
                upd_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [T-1:0] m;
        int w;
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_req_pr = '0;
        gnt_pr      = '0;
        #12;
        check("rst_req_pr", req_pr, '0);
        check("rst_update", T'(update), T'(0));
        check("rst_busy", T'(busy), T'(0));
        check("rst_done", T'(done), T'(0));
        check("rst_timeout", T'(timeout), T'(0));
        check("rst_elapsed", T'(elapsed), T'(0));
        check("rst_error", T'(error), T'(0));
        check("rst_ready", T'(load_ready), T'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-drain must discard everything without a done pulse.
        load_valid  = 1'b1;
        load_req_pr = '1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        check("mid_busy_before", T'(busy), T'(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_req_pr", req_pr, '0);
        check("mid_busy", T'(busy), T'(0));
        check("mid_ready", T'(load_ready), T'(1));
        check("mid_done", T'(done), T'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        m = '0;
        m[3] = 1'b1;
        run_matrix(m, M_GREEDY);
        run_matrix('0, M_RAND);
        m = '0;
        m[71:64] = '1;
        run_matrix(m, M_ONE);
        m = '0;
        m[5] = 1'b1;
        m[100] = 1'b1;
        run_matrix(m, M_NONE);
        run_matrix('1, M_GREEDY);

        for (int r = 0; r < 30; r++) begin
            m = '0;
            if (r % 7 != 3) begin
                for (int k = 0; k < T; k++) m[k] = ($urandom_range(0, 9) == 0);
            end
            run_matrix(m, (r % 4 == 0) ? M_GREEDY : M_RAND);
            check("error_legal", T'(error), T'(exp_error));
        end

        m = '0;
        m[0] = 1'b1;
        m[1] = 1'b1;
        run_matrix(m, M_ILLEGAL);
        check("error_after_illegal", T'(error), T'(exp_error));
        m = '0;
        m[9] = 1'b1;
        run_matrix(m, M_GREEDY);
        check("error_sticky", T'(error), T'(exp_error));

        w = 0;
        while (sb_q.size() != 0 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("scoreboard_empty", T'(sb_q.size()), T'(0));
        repeat (2) @(posedge clk);
        #1;
        check("error_final", T'(error), T'(exp_error));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
